// File: rtl/spi_slave_frontend_if.sv
// Bus bundle between the SPI slave front end and its neighbours: serial pins toward the master,
// command/readback handshake toward the memory array.
interface spi_slave_frontend_if #(
   parameter int ADDR_SIZE = 8
);
   logic                   SS_n;
   logic                   MOSI;
   logic                   MISO;
   logic [ADDR_SIZE+1:0]   rx_data;
   logic                   rx_valid;
   logic [ADDR_SIZE-1:0]   tx_data;
   logic                   tx_valid;

   modport slave (
      input  SS_n, MOSI, tx_data, tx_valid,
      output MISO, rx_data, rx_valid
   );

   modport master (
      output SS_n, MOSI, tx_data, tx_valid,
      input  MISO, rx_data, rx_valid
   );
endinterface

// File: rtl/spi_slave_frontend.sv
// SPI slave front end: deserialises MOSI into command words for the memory array and
// serialises the memory's read byte back out on MISO.
module spi_slave_frontend #(
   parameter int ADDR_SIZE = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   spi_slave_frontend_if.slave   bus
);
   localparam int W   = ADDR_SIZE + 2;
   localparam int CW  = $clog2(ADDR_SIZE + 3);
   localparam int TXW = $clog2(ADDR_SIZE + 1);

   localparam logic [CW-1:0]  CNT_FULL = CW'(W);
   localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);
   localparam logic [TXW-1:0] TX_LAST  = TXW'(ADDR_SIZE);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] CHK_CMD   = 3'd1;
   localparam logic [2:0] WRITE     = 3'd2;
   localparam logic [2:0] READ_ADD  = 3'd3;
   localparam logic [2:0] READ_DATA = 3'd4;

   logic [2:0]           state_q,        state_d;
   logic [CW-1:0]        cnt_q,          cnt_d;
   logic [W-2:0]         rx_shift_q,     rx_shift_d;
   logic [W-1:0]         rx_data_q,      rx_data_d;
   logic                 rx_valid_q,     rx_valid_d;
   logic                 miso_q,         miso_d;
   logic                 rd_addr_seen_q, rd_addr_seen_d;
   logic [ADDR_SIZE-1:0] tx_shift_q,     tx_shift_d;
   logic [TXW-1:0]       tx_cnt_q,       tx_cnt_d;
   logic                 tx_busy_q,      tx_busy_d;
   logic                 tx_done_q,      tx_done_d;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      rx_shift_d     = rx_shift_q;
      rx_data_d      = rx_data_q;
      rx_valid_d     = 1'b0;
      miso_d         = 1'b0;
      rd_addr_seen_d = rd_addr_seen_q;
      tx_shift_d     = tx_shift_q;
      tx_cnt_d       = tx_cnt_q;
      tx_busy_d      = tx_busy_q;
      tx_done_d      = tx_done_q;

      // Deselect aborts any frame; a partial word or byte leaves rd_addr_seen untouched.
      if (state_q != IDLE && bus.SS_n) begin
         state_d   = IDLE;
         cnt_d     = '0;
         tx_cnt_d  = '0;
         tx_busy_d = 1'b0;
         tx_done_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d     = '0;
               tx_cnt_d  = '0;
               tx_busy_d = 1'b0;
               tx_done_d = 1'b0;
               if (!bus.SS_n) state_d = CHK_CMD;
            end
            CHK_CMD: begin
               rx_shift_d = {{(W-2){1'b0}}, bus.MOSI};
               cnt_d      = CW'(1);
               if (!bus.MOSI)          state_d = WRITE;
               else if (rd_addr_seen_q) state_d = READ_DATA;
               else                    state_d = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
               if (cnt_q != CNT_FULL) begin
                  rx_shift_d = {rx_shift_q[W-3:0], bus.MOSI};
                  cnt_d      = cnt_q + CW'(1);
                  if (cnt_q == CNT_LAST) begin
                     rx_data_d  = {rx_shift_q, bus.MOSI};
                     rx_valid_d = 1'b1;
                     if (state_q == READ_ADD) rd_addr_seen_d = 1'b1;
                  end
               end else if (state_q == READ_DATA) begin
                  // Readback: one wait window for tx_valid, then a single byte, MSB first.
                  if (tx_busy_q) begin
                     if (tx_cnt_q == TX_LAST) begin
                        tx_busy_d      = 1'b0;
                        tx_done_d      = 1'b1;
                        rd_addr_seen_d = 1'b0;
                     end else begin
                        miso_d     = tx_shift_q[ADDR_SIZE-1];
                        tx_shift_d = {tx_shift_q[ADDR_SIZE-2:0], 1'b0};
                        tx_cnt_d   = tx_cnt_q + TXW'(1);
                     end
                  end else if (!tx_done_q && bus.tx_valid) begin
                     miso_d     = bus.tx_data[ADDR_SIZE-1];
                     tx_shift_d = {bus.tx_data[ADDR_SIZE-2:0], 1'b0};
                     tx_cnt_d   = TXW'(1);
                     tx_busy_d  = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         rx_shift_q     <= '0;
         rx_data_q      <= '0;
         rx_valid_q     <= 1'b0;
         miso_q         <= 1'b0;
         rd_addr_seen_q <= 1'b0;
         tx_shift_q     <= '0;
         tx_cnt_q       <= '0;
         tx_busy_q      <= 1'b0;
         tx_done_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         rx_shift_q     <= rx_shift_d;
         rx_data_q      <= rx_data_d;
         rx_valid_q     <= rx_valid_d;
         miso_q         <= miso_d;
         rd_addr_seen_q <= rd_addr_seen_d;
         tx_shift_q     <= tx_shift_d;
         tx_cnt_q       <= tx_cnt_d;
         tx_busy_q      <= tx_busy_d;
         tx_done_q      <= tx_done_d;
      end
   end

   assign bus.MISO     = miso_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_slave_frontend.sv
// Directed bench for spi_slave_frontend: frames are shifted in MSB first and every result is
// compared against hand-computed constants.
module tb_spi_slave_frontend;
   logic clk;
   logic rst;
   int   testsRun;
   int   testsFailed;
   int   pulseCount;
   int   misoHighCount;
   int   pulseSnap;
   int   misoSnap;
   logic [7:0] rxByte;

   spi_slave_frontend_if #(.ADDR_SIZE(8)) bus ();

   spi_slave_frontend #(.ADDR_SIZE(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Running totals of rx_valid pulses and MISO-high cycles, sampled mid-cycle.
   initial begin
      pulseCount    = 0;
      misoHighCount = 0;
   end
   always @(negedge clk) begin
      if (bus.rx_valid) pulseCount++;
      if (bus.MISO)     misoHighCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Drive inputs for one edge, then sample 2 time units after that edge.
   task automatic applyStimulus(input logic ss, input logic mosi, input logic tv, input logic [7:0] td);
      bus.SS_n     = ss;
      bus.MOSI     = mosi;
      bus.tx_valid = tv;
      bus.tx_data  = td;
      @(posedge clk);
      #2;
   endtask

   task automatic sendFrame(input logic [9:0] word, input logic tv);
      applyStimulus(1'b0, 1'b0, tv, 8'h00);
      for (int i = 9; i >= 0; i--) applyStimulus(1'b0, word[i], tv, 8'h00);
   endtask

   task automatic deselect();
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic readByte(output logic [7:0] b, input int nBits);
      b = 8'h00;
      b[7] = bus.MISO;
      for (int i = 6; i >= 8 - nBits; i--) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
         b[i] = bus.MISO;
      end
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rst         = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF);
      checkOutput("reset rx_data",  32'(bus.rx_data), 32'h000);
      checkOutput("reset rx_valid", 32'(bus.rx_valid), 32'd0);
      checkOutput("reset MISO",     32'(bus.MISO), 32'd0);
      checkOutput("reset state",    32'(dut.state_q), 32'd0);
      checkOutput("reset rd_seen",  32'(dut.rd_addr_seen_q), 32'd0);
      rst = 1'b0;
      deselect();

      // Write address
      pulseSnap = pulseCount;
      misoSnap  = misoHighCount;
      sendFrame(10'h011, 1'b0);
      checkOutput("wa rx_valid", 32'(bus.rx_valid), 32'd1);
      checkOutput("wa rx_data",  32'(bus.rx_data), 32'h011);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput("wa pulse end", 32'(bus.rx_valid), 32'd0);
      deselect();
      checkOutput("wa idle",   32'(dut.state_q), 32'd0);
      checkOutput("wa pulses", 32'(pulseCount - pulseSnap), 32'd1);
      checkOutput("wa miso",   32'(misoHighCount - misoSnap), 32'd0);

      // Write data, then linger selected
      pulseSnap = pulseCount;
      sendFrame(10'h1A5, 1'b0);
      checkOutput("wd rx_data", 32'(bus.rx_data), 32'h1A5);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, i[0], 1'b0, 8'h00);
      checkOutput("wd pulses", 32'(pulseCount - pulseSnap), 32'd1);
      deselect();

      // Abort after 5 bits of 01_1111_0000
      pulseSnap = pulseCount;
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      deselect();
      checkOutput("abort idle",    32'(dut.state_q), 32'd0);
      checkOutput("abort pulses",  32'(pulseCount - pulseSnap), 32'd0);
      checkOutput("abort rx_data", 32'(bus.rx_data), 32'h1A5);
      sendFrame(10'h1F0, 1'b0);
      checkOutput("post-abort rx_data",  32'(bus.rx_data), 32'h1F0);
      checkOutput("post-abort rx_valid", 32'(bus.rx_valid), 32'd1);
      deselect();

      // Read address then read data 0xFF
      sendFrame(10'h211, 1'b0);
      checkOutput("ra state",   32'(dut.state_q), 32'd3);
      checkOutput("ra rx_data", 32'(bus.rx_data), 32'h211);
      checkOutput("ra rd_seen", 32'(dut.rd_addr_seen_q), 32'd1);
      deselect();
      sendFrame(10'h3C3, 1'b0);
      checkOutput("rd state",   32'(dut.state_q), 32'd4);
      checkOutput("rd rx_data", 32'(bus.rx_data), 32'h3C3);
      misoSnap = misoHighCount;
      applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
      readByte(rxByte, 8);
      checkOutput("rd byte FF", 32'(rxByte), 32'h0FF);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
      checkOutput("rd miso after", 32'(bus.MISO), 32'd0);
      checkOutput("rd rd_seen clr", 32'(dut.rd_addr_seen_q), 32'd0);
      checkOutput("rd high cycles", 32'(misoHighCount - misoSnap), 32'd8);
      deselect();
      sendFrame(10'h2AA, 1'b0);
      checkOutput("third frame read_add", 32'(dut.state_q), 32'd3);
      deselect();

      // Reset during the 4th MISO bit of 0xA5
      sendFrame(10'h300, 1'b0);
      checkOutput("rst-rd state", 32'(dut.state_q), 32'd4);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'hA5);
      readByte(rxByte, 4);
      checkOutput("rst-rd first nibble", 32'(rxByte), 32'h0A0);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      rst = 1'b0;
      checkOutput("rst-rd MISO",    32'(bus.MISO), 32'd0);
      checkOutput("rst-rd state",   32'(dut.state_q), 32'd0);
      checkOutput("rst-rd rd_seen", 32'(dut.rd_addr_seen_q), 32'd0);
      deselect();

      // tx_valid outside the wait window is ignored
      misoSnap = misoHighCount;
      sendFrame(10'h2F0, 1'b1);
      checkOutput("tv read_add state", 32'(dut.state_q), 32'd3);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
      deselect();
      sendFrame(10'h3F0, 1'b1);
      checkOutput("tv read_data state", 32'(dut.state_q), 32'd4);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'hFF);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'hFF);
      checkOutput("tv early miso", 32'(misoHighCount - misoSnap), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h81);
      readByte(rxByte, 8);
      checkOutput("tv byte 81", 32'(rxByte), 32'h081);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
      checkOutput("tv after byte", 32'(bus.MISO), 32'd0);
      deselect();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
